// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types and constants for the core
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hz_state_t;

    localparam int REG_AW    = 4;
    localparam int DRAIN_CYC = 3;

endpackage

// File: rtl/perf_sat_counter.sv
// rtl/perf_sat_counter.sv - saturating event counter with synchronous clear
// Ports: clk; inc counts one event; clr zeroes the count (wins over inc);
//        count holds at all-ones instead of wrapping.
module perf_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline advance/hold/bubble sequencing for the 5-stage core
// Ports: clk, rst (sync, active-high); ID-stage operand/HALT info; EX-stage
//        destination, load, MDU and branch status; mem_busy from data memory.
//        Outputs are per-register enables and flushes, mdu_capture, halted,
//        and the saturating stall_cycles counter.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MDU_LAT = 8,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic              id_halt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr,
    input  logic              ex_is_load,
    input  logic              ex_mdu_start,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic              mdu_capture,
    output logic              halted,
    output logic [PERF_W-1:0] stall_cycles
);

    // The op is already in EX during the RUN cycle that sees it, so the wait
    // state covers the remaining MDU_LAT-1 cycles, ending with cnt=0.
    localparam logic [7:0] MDU_LOAD   = 8'(MDU_LAT - 2);
    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYC - 1);

    hz_state_t  state, state_d;
    logic [7:0] cnt, cnt_d;
    logic       load_use;
    logic       stall_inc;

    // r0 is an ordinary register, so no zero-register exclusion here.
    assign load_use = id_valid && ex_is_load && ex_wr &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mdu_capture  = 1'b0;
        state_d      = state;
        cnt_d        = cnt;

        if (rst || mem_busy || (state == HALTED)) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else begin
            case (state)
                DRAIN: begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                    if (cnt == 8'd0) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt - 8'd1;
                    end
                end
                MDU_WAIT: begin
                    pc_en    = 1'b0;
                    if_id_en = 1'b0;
                    id_ex_en = 1'b0;
                    if (cnt != 8'd0) begin
                        ex_mem_flush = 1'b1;
                        cnt_d        = cnt - 8'd1;
                    end else begin
                        mdu_capture = 1'b1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (ex_mdu_start) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_flush = 1'b1;
                        cnt_d        = MDU_LOAD;
                        state_d      = MDU_WAIT;
                    end else if (ex_branch_taken) begin
                        // The instruction in ID is on the wrong path, so its
                        // hazard or HALT never matters.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (id_valid && id_halt) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        cnt_d       = DRAIN_LOAD;
                        state_d     = DRAIN;
                    end else if (load_use) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    assign halted    = !rst && (state == HALTED);
    assign stall_inc = !rst && (state != HALTED) && !pc_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    perf_sat_counter #(
        .W(PERF_W)
    ) u_stall_cnt (
        .clk  (clk),
        .inc  (stall_inc),
        .clr  (rst),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic       halt;
        logic [3:0] rd;
        logic       wr;
        logic       ld;
        logic       mdu;
        logic       br;
        logic       busy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [9:0] ctl;
        int         stall;
    } vec_t;

    typedef struct {
        logic [9:0] ctl;
        int         stall;
    } exp_t;

    // ctl = {pc, if_id, id_ex, ex_mem, mem_wb, f_if_id, f_id_ex, f_ex_mem, capture, halted}
    localparam logic [9:0] C_RUN  = 10'b11111_000_0_0;
    localparam logic [9:0] C_ZERO = 10'b00000_000_0_0;
    localparam logic [9:0] C_BUB  = 10'b00111_010_0_0;
    localparam logic [9:0] C_MDU  = 10'b00011_001_0_0;
    localparam logic [9:0] C_CAP  = 10'b00011_000_1_0;
    localparam logic [9:0] C_BR   = 10'b11111_110_0_0;
    localparam logic [9:0] C_HLT  = 10'b00000_000_0_1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_rs1_used, id_rs2_used, id_halt;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic       ex_wr, ex_is_load, ex_mdu_start, ex_branch_taken, mem_busy;

    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mdu_capture, halted;
    logic [15:0] stall_cycles;

    logic       pc_en4, if_id_en4, id_ex_en4, ex_mem_en4, mem_wb_en4;
    logic       if_id_flush4, id_ex_flush4, ex_mem_flush4, mdu_capture4, halted4;
    logic [3:0] stall_cycles4;

    hazard_ctrl #(.MDU_LAT(8), .PERF_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_halt(id_halt),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_mdu_start(ex_mdu_start),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mdu_capture(mdu_capture), .halted(halted),
        .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.MDU_LAT(8), .PERF_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_halt(id_halt),
        .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_mdu_start(ex_mdu_start),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_en(id_ex_en4), .ex_mem_en(ex_mem_en4),
        .mem_wb_en(mem_wb_en4), .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
        .ex_mem_flush(ex_mem_flush4), .mdu_capture(mdu_capture4), .halted(halted4),
        .stall_cycles(stall_cycles4)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    exp_t sb[$];

    function automatic in_t idle();
        in_t v = '0;
        v.valid = 1'b1;
        v.rs1   = 4'd1;
        v.rs2   = 4'd2;
        v.u1    = 1'b1;
        v.u2    = 1'b1;
        v.rd    = 4'd3;
        v.wr    = 1'b1;
        return v;
    endfunction

    function automatic in_t lu(input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        in_t v = idle();
        v.rd  = rd;
        v.rs1 = rs1;
        v.rs2 = rs2;
        v.ld  = 1'b1;
        return v;
    endfunction

    task automatic add(input in_t v, input logic [9:0] c, input int s);
        vec_t e;
        e.in    = v;
        e.ctl   = c;
        e.stall = s;
        tbl.push_back(e);
    endtask

    task automatic drive(input in_t v);
        rst             = v.rst;
        id_valid        = v.valid;
        id_rs1          = v.rs1;
        id_rs2          = v.rs2;
        id_rs1_used     = v.u1;
        id_rs2_used     = v.u2;
        id_halt         = v.halt;
        ex_rd           = v.rd;
        ex_wr           = v.wr;
        ex_is_load      = v.ld;
        ex_mdu_start    = v.mdu;
        ex_branch_taken = v.br;
        mem_busy        = v.busy;
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle of stimulus, score it, then advance to just after the next edge.
    task automatic apply(input string name, input in_t v, input logic [9:0] c, input int s);
        exp_t e;
        logic [9:0] act;
        drive(v);
        e.ctl   = c;
        e.stall = s;
        sb.push_back(e);
        #2;
        e   = sb.pop_front();
        act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, mdu_capture, halted};
        check({name, ".ctl"}, int'(act), int'(e.ctl));
        check({name, ".stall"}, int'(stall_cycles), e.stall);
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_t v;
        int  s;

        v     = idle();
        v.rst = 1'b1;
        drive(v);
        repeat (2) @(posedge clk);
        #1;

        // Reset and single-cycle hazard decoding
        add(v, C_ZERO, 0);
        add(idle(), C_RUN, 0);
        add(lu(4'd5, 4'd5, 4'd2), C_BUB, 0);
        add(idle(), C_RUN, 1);
        add(lu(4'd7, 4'd1, 4'd7), C_BUB, 1);
        v = lu(4'd5, 4'd5, 4'd2); v.u1 = 1'b0;
        add(v, C_RUN, 2);
        v = lu(4'd5, 4'd5, 4'd2); v.wr = 1'b0;
        add(v, C_RUN, 2);
        add(lu(4'd0, 4'd0, 4'd2), C_BUB, 2);
        v = lu(4'd5, 4'd5, 4'd2); v.valid = 1'b0;
        add(v, C_RUN, 3);
        v = lu(4'd5, 4'd5, 4'd2); v.br = 1'b1; v.halt = 1'b1;
        add(v, C_BR, 3);
        add(idle(), C_RUN, 3);

        // MDU op, MDU_LAT=8: freeze 8 cycles, capture on the last
        v = idle(); v.mdu = 1'b1;
        for (int i = 0; i < 7; i++) add(v, C_MDU, 3 + i);
        add(v, C_CAP, 10);
        add(idle(), C_RUN, 11);

        // Same op with mem_busy at T+2..T+4: capture slides to T+10
        add(v, C_MDU, 11);
        add(v, C_MDU, 12);
        v.busy = 1'b1;
        for (int i = 0; i < 3; i++) add(v, C_ZERO, 13 + i);
        v.busy = 1'b0;
        for (int i = 0; i < 5; i++) add(v, C_MDU, 16 + i);
        add(v, C_CAP, 21);
        add(idle(), C_RUN, 22);

        // HALT: drain three cycles ignoring branch/MDU, then stay halted
        v = idle(); v.halt = 1'b1;
        add(v, C_BUB, 22);
        v = idle(); v.br = 1'b1; v.mdu = 1'b1;
        for (int i = 0; i < 3; i++) add(v, C_BUB, 23 + i);
        add(v, C_HLT, 26);
        v.busy = 1'b1;
        add(v, C_HLT, 26);
        v.busy = 1'b0;
        add(v, C_HLT, 26);
        v = idle(); v.rst = 1'b1;
        add(v, C_ZERO, 26);
        add(idle(), C_RUN, 0);

        for (int i = 0; i < tbl.size(); i++)
            apply($sformatf("vec%0d", i), tbl[i].in, tbl[i].ctl, tbl[i].stall);

        // 20 load-use stalls: wide counter reaches 20, 4-bit counter sticks at 15
        v = idle(); v.rst = 1'b1;
        apply("rst2", v, C_ZERO, 0);
        s = 0;
        for (int i = 0; i < 20; i++) begin
            apply("lu_loop", lu(4'd9, 4'd2, 4'd9), C_BUB, s);
            s++;
            apply("lu_gap", idle(), C_RUN, s);
        end
        check("sat4", int'(stall_cycles4), 15);

        // Reset in the middle of MDU_WAIT: back to RUN, no capture pulse
        v = idle(); v.mdu = 1'b1;
        apply("mdu_t0", v, C_MDU, 20);
        apply("mdu_t1", v, C_MDU, 21);
        apply("mdu_t2", v, C_MDU, 22);
        v.rst = 1'b1;
        apply("mdu_rst", v, C_ZERO, 23);
        for (int i = 0; i < 8; i++) apply("post_rst", idle(), C_RUN, 0);
        check("sat4_clr", int'(stall_cycles4), 0);
        check("cap4_quiet", int'(mdu_capture4), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It sits beside the EX-stage forwarding logic and decides, each cycle, which pipeline registers advance, hold or take a bubble. It covers load-use hazards, multi-cycle MDU (mul/div) operations, data-memory wait states, taken-branch squashes and HALT drain. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- MDU_LAT, 8, cycles an MDU op occupies EX (legal range 2..255)
- PERF_W, 16, width of stall counter

Ports:
- clk  input  1  core clock
- rst  input  1  reset, synchronous, active-high
- id_valid  input  1  ID holds a real instruction
- id_rs1, id_rs2  input  4  ID source registers
- id_rs1_used, id_rs2_used  input  1  source actually read
- id_halt  input  1  ID instruction is HALT
- ex_rd  input  4  EX destination register
- ex_wr  input  1  EX writes register file
- ex_is_load  input  1  EX is a load
- ex_mdu_start  input  1  EX holds an MDU op
- ex_branch_taken  input  1  EX resolved taken branch/jump
- mem_busy  input  1  data memory not ready
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  register enables
- if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  load bubble into register
- mdu_capture  output  1  EX/MEM captures MDU result this cycle
- halted  output  1  core stopped
- stall_cycles  output  PERF_W  saturating count of cycles with pc_en=0, excluding HALTED

## Operation
- The state machine has four states: RUN, MDU_WAIT, DRAIN, HALTED. There is one 8-bit down-counter cnt.
- Register numbering: r0 is an ordinary register. It gets no special case.
- Outputs are combinational from state, cnt and inputs. Default: all enables 1, all flushes 0, mdu_capture 0.
- Priority is evaluated every cycle. The first matching rule wins.
  1. rst=1: all enables 0, flushes 0, mdu_capture 0, halted 0. Next state is RUN, cnt=0, stall_cycles=0.
  2. mem_busy=1, any state: all enables 0 and flushes 0. State, cnt and stall_cycles hold, except that stall_cycles increments if the state is not HALTED.
  3. HALTED: all enables 0, halted=1. Stays until rst.
  4. DRAIN: pc_en=0, if_id_en=0, id_ex_flush=1. EX/MEM and MEM/WB advance. cnt decrements; at cnt=0 the next state is HALTED. ex_branch_taken and ex_mdu_start are ignored.
  5. MDU_WAIT: pc_en=if_id_en=id_ex_en=0.
     - If cnt≠0: ex_mem_flush=1 and cnt decrements.
     - If cnt=0: mdu_capture=1, ex_mem_flush=0, next state RUN.
  6. RUN with ex_mdu_start: same front-end freeze with ex_mem_flush=1. cnt←MDU_LAT-2, next state MDU_WAIT.
  7. RUN with ex_branch_taken: if_id_flush=1 and id_ex_flush=1. pc_en=1 so the PC loads the target. Any load-use hazard or HALT in ID is discarded.
  8. RUN with id_valid & id_halt: pc_en=0, if_id_en=0, id_ex_flush=1. cnt←2, next state DRAIN.
  9. RUN with a load-use hazard: pc_en=0, if_id_en=0, id_ex_flush=1, for one cycle only.
     - Hazard condition: id_valid & ex_is_load & ex_wr & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- stall_cycles increments in any non-reset, non-HALTED cycle with pc_en=0. It saturates at all-ones and does not wrap.
- ex_mdu_start must stay high while the MDU op is held in EX. It is ignored outside RUN.

## Timing
- Load-use hazard: exactly 1 bubble cycle. Forwarding from MEM covers the following cycle.
- MDU op first seen in RUN at cycle T, with no mem_busy:
  - Front end frozen T..T+MDU_LAT-1.
  - ex_mem_flush=1 for T..T+MDU_LAT-2.
  - mdu_capture=1 only at T+MDU_LAT-1.
  - RUN from T+MDU_LAT.
- Each mem_busy cycle delays every pending event by one cycle. cnt does not count during mem_busy.
- HALT accepted at T: DRAIN during T+1..T+3, halted=1 from T+4.
- Reset taking effect mid-MDU or mid-DRAIN returns the block to RUN on the next edge. No capture pulse is emitted.

## Structure
- The shared cpu_pkg holds:
  - enum hz_state_t {RUN, MDU_WAIT, DRAIN, HALTED}
  - localparam REG_AW=4
  - localparam DRAIN_CYC=3
- One sub-module, perf_sat_counter (parameter W; ports inc, clr, count), instantiated for stall_cycles.

## Test plan
- ex_is_load=1, ex_wr=1, ex_rd=5, id_rs1=5, id_rs1_used=1 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles=1.
- MDU_LAT=8, ex_mdu_start held from T → front-end enables 0 for T..T+7, mdu_capture only at T+7, RUN at T+8, stall_cycles=8.
- Same MDU test with mem_busy=1 at T+2..T+4 → all enables 0 in those cycles, mdu_capture moves to T+10.
- ex_branch_taken=1 with a load-use hazard and id_halt in ID in the same cycle → pc_en=1, if_id_flush=1, id_ex_flush=1, state stays RUN.
- id_halt at T → pc_en=0 for T..T+3, halted=1 from T+4, enables stay 0 until rst; stall_cycles=4.
- PERF_W=4, 20 load-use stalls → stall_cycles=15. Then rst=1 in the middle of MDU_WAIT → next cycle RUN, stall_cycles=0, mdu_capture never pulses.
